sha_stream_frontend: RTL



---
 rtl/sha_pkg.sv | 8 +
 rtl/sha_word_select.sv | 19 +
 rtl/sha_stream_frontend.sv | 112 +++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// sha_pkg: shared constants and FSM encodings for the SHA byte-stream front end.
package sha_pkg;
  localparam int BLOCK_BITS = 512;
  localparam int LEN_FIELD_BITS = 64;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  typedef enum logic [2:0] {S_FILL, S_PAD, S_LEN, S_EMIT, S_WAIT} state_t;
  typedef enum logic [1:0] {T_FILL, T_PAD, T_LEN, T_FIN} tgt_t;
endpackage

// File: rtl/sha_word_select.sv
// sha_word_select: 32-bit word readout of a digest, zero for out-of-range selects.
module sha_word_select #(
  parameter int N_WORDS = 5,
  parameter int SEL_W = 3
) (
  input  logic [32*N_WORDS-1:0] words,
  input  logic [SEL_W-1:0]      sel,
  output logic [31:0]           word
);
  logic [31:0] table_w [2**SEL_W];
  for (genvar i = 0; i < 2**SEL_W; i++) begin : g_w
    if (i < N_WORDS) begin : g_in
      assign table_w[i] = words[32*i +: 32];
    end else begin : g_out
      assign table_w[i] = '0;
    end
  end
  assign word = table_w[sel];
endmodule

// File: rtl/sha_stream_frontend.sv
// sha_stream_frontend: packs a byte stream into SHA-padded 512-bit blocks and captures the final digest.
module sha_stream_frontend
  import sha_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int N_WORDS = 5,
  parameter int SEL_W = 3
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [BLOCK_BITS-1:0]  blk_data,
  output logic                   blk_valid,
  output logic                   blk_first,
  input  logic                   blk_ready,
  input  logic                   core_done,
  input  logic [32*N_WORDS-1:0]  digest_in,
  output logic [32*N_WORDS-1:0]  digest_out,
  output logic                   digest_valid,
  input  logic [SEL_W-1:0]       sel,
  output logic [31:0]            sel_word,
  output logic                   busy,
  output logic                   err_overflow
);
  state_t state, state_nx;
  tgt_t tgt, tgt_nx;
  logic [63:0][7:0] buf_q;
  logic [6:0] idx, idx_inc;
  logic [CNT_W-1:0] count, count_inc;
  logic first, accept;
  logic [LEN_FIELD_BITS-1:0] len_field;
  assign in_ready = state == S_FILL && !sys_rst;
  assign accept = in_valid && in_ready;
  assign idx_inc = idx + 7'd1;
  assign count_inc = count + CNT_W'(1);
  assign len_field = LEN_FIELD_BITS'({count, 3'b000});
  assign blk_data = buf_q;
  assign blk_valid = state == S_EMIT;
  assign blk_first = state == S_EMIT && first;
  assign busy = !(state == S_FILL && idx == 7'd0);
  always_comb begin
    state_nx = state;
    tgt_nx = tgt;
    case (state)
      S_FILL: if (accept) begin
        state_nx = in_last ? S_PAD : idx_inc == 7'd64 ? S_EMIT : S_FILL;
        tgt_nx = T_FILL;
      end
      S_PAD: begin
        state_nx = (idx != 7'd64 && idx_inc <= 7'd56) ? S_LEN : S_EMIT;
        tgt_nx = idx == 7'd64 ? T_PAD : T_LEN;
      end
      S_LEN: begin
        state_nx = S_EMIT;
        tgt_nx = T_FIN;
      end
      S_EMIT: state_nx = blk_ready ? S_WAIT : S_EMIT;
      S_WAIT: if (core_done) state_nx = tgt == T_PAD ? S_PAD : tgt == T_LEN ? S_LEN : S_FILL;
      default: state_nx = S_FILL;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= S_FILL;
      tgt <= T_FILL;
      buf_q <= '0;
      idx <= '0;
      count <= '0;
      first <= 1'b1;
      digest_out <= '0;
      digest_valid <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state <= state_nx;
      tgt <= tgt_nx;
      case (state)
        S_FILL: if (accept) begin
          buf_q[6'd63 - idx[5:0]] <= in_data;
          idx <= idx_inc;
          count <= count_inc;
          digest_valid <= 1'b0;
          if (count_inc == '0) err_overflow <= 1'b1;
        end
        S_PAD: if (idx != 7'd64) begin
          buf_q[6'd63 - idx[5:0]] <= PAD_BYTE;
          idx <= idx_inc;
        end
        S_LEN: buf_q[7:0] <= len_field;
        // Every block boundary zeroes the buffer, which supplies the padding zero fill.
        S_WAIT: if (core_done) begin
          buf_q <= '0;
          idx <= '0;
          first <= tgt == T_FIN;
          if (tgt == T_FIN) begin
            digest_out <= digest_in;
            digest_valid <= 1'b1;
            count <= '0;
          end
        end
        default: ;
      endcase
    end
  end
  sha_word_select #(.N_WORDS(N_WORDS), .SEL_W(SEL_W)) u_sel (
    .words(digest_out),
    .sel(sel),
    .word(sel_word)
  );
endmodule
